// File: rtl/mips_encode.sv
// rtl/mips_encode.sv - MIPS ALU request encoder feeding a 4-entry instruction queue
module mips_encode_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready
);
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        push;
  logic        pop;

  assign in_tready  = (count != 3'd4);
  assign out_tvalid = (count != 3'd0);
  assign out_tdata  = out_tvalid ? mem[rd_ptr] : 32'h0000_0000;
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_tdata;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end
endmodule

module mips_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic        use_imm,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        except,
  output logic [7:0]  err_count
);
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic        encodable;
  logic [31:0] word;
  logic        accept;

  // sub and nor have no immediate form in this encoder
  always_comb begin
    funct     = 6'h00;
    opcode    = 6'h00;
    encodable = 1'b1;
    case (alu_op)
      3'b010: begin funct = 6'h20; opcode = 6'h08; end
      3'b011: begin funct = 6'h22; encodable = !use_imm; end
      3'b100: begin funct = 6'h24; opcode = 6'h0C; end
      3'b101: begin funct = 6'h25; opcode = 6'h0D; end
      3'b110: begin funct = 6'h27; encodable = !use_imm; end
      3'b111: begin funct = 6'h26; opcode = 6'h0E; end
      default: encodable = 1'b0;
    endcase
    word = use_imm ? {opcode, rs, rd, imm} : {6'b000000, rs, rt, rd, 5'b00000, funct};
  end

  assign accept = in_valid && in_ready;

  mips_encode_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (word),
    .in_tvalid  (accept && encodable),
    .in_tready  (in_ready),
    .out_tdata  (out_instr),
    .out_tvalid (out_valid),
    .out_tready (out_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      except    <= 1'b0;
      err_count <= 8'h00;
      out_addr  <= 32'h0040_0000;
    end else begin
      except <= accept && !encodable;
      if (accept && !encodable && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (out_valid && out_ready) out_addr <= out_addr + 32'd4;
    end
  end
endmodule
